// File: rtl/twophase_tx_fsm.sv
// twophase_tx_fsm: four-phase req/ack transmitter; optional ack timeout and err port under TX_TIMEOUT_EN
module twophase_tx_fsm #(
  parameter int DATA_WIDTH   = 8,
  parameter int SETUP_CYCLES = 1,
  parameter int SYNC_STAGES  = 2
`ifdef TX_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  v,
  input  logic [DATA_WIDTH-1:0] input_tx,
  input  logic                  ack,
  output logic                  req,
  output logic [DATA_WIDTH-1:0] output_tx,
  output logic                  ready,
  output logic                  done
`ifdef TX_TIMEOUT_EN
  , output logic                err
`endif
);
  typedef enum logic [1:0] {IDLE = 2'b00, SETUP = 2'b01, WAIT_ACK = 2'b10, WAIT_REL = 2'b11} state_e;
  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ack_s;
  logic [3:0]             cnt_q, cnt_d;
  logic                   req_q, req_d, done_q, done_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
`ifdef TX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          tmo_hit, err_q, err_d;
  assign tmo_hit = tmo_q == TW'(TIMEOUT_CYCLES - 1);
  assign err     = err_q;
`endif
  assign ack_s     = sync_q[SYNC_STAGES-1];
  assign ready     = (state_q == IDLE) && !ack_s;
  assign req       = req_q;
  assign output_tx = data_q;
  assign done      = done_q;
  // ack crosses from the receiver's domain; only the last stage feeds the FSM
  always_ff @(posedge clk or negedge reset)
    if (!reset) sync_q <= '0;
    else sync_q <= {sync_q[SYNC_STAGES-2:0], ack};
  // state, setup counter and the registered bus-facing outputs
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      done_q  <= 1'b0;
      data_q  <= '0;
`ifdef TX_TIMEOUT_EN
      tmo_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      done_q  <= done_d;
      data_q  <= data_d;
`ifdef TX_TIMEOUT_EN
      tmo_q   <= tmo_d;
      err_q   <= err_d;
`endif
    end
  // next state: req is only ever high in WAIT_ACK, data only loads on the IDLE capture
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = 1'b0;
    done_d  = 1'b0;
    data_d  = data_q;
`ifdef TX_TIMEOUT_EN
    err_d   = 1'b0;
`endif
    case (state_q)
      IDLE:
        if (v && ready) begin
          data_d  = input_tx;
          cnt_d   = '0;
          state_d = SETUP;
        end
      SETUP: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'(SETUP_CYCLES - 1)) begin
          req_d   = 1'b1;
          state_d = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        req_d = !ack_s;
        if (ack_s) state_d = WAIT_REL;
`ifdef TX_TIMEOUT_EN
        else if (tmo_hit) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = IDLE;
        end
`endif
      end
      WAIT_REL:
        if (!ack_s) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
`ifdef TX_TIMEOUT_EN
        else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
`endif
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
`ifdef TX_TIMEOUT_EN
    tmo_d = ((state_q == WAIT_ACK || state_q == WAIT_REL) && state_d == state_q) ? tmo_q + TW'(1) : '0;
`endif
  end
endmodule

// File: tb/tb_twophase_tx_fsm.sv
// tb_twophase_tx_fsm: randomized scoreboard bench for twophase_tx_fsm with a transaction-level reference
`timescale 1ns/1ps
module tb_twophase_tx_fsm;
  localparam int DW = 8, SU = 4, SS = 2, TO = 10;
`ifdef TX_TIMEOUT_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b0, v = 1'b0, ack = 1'b0;
  logic [DW-1:0] input_tx = '0;
  logic req, ready, done;
  logic [DW-1:0] output_tx;
`ifdef TX_TIMEOUT_EN
  logic err;
`endif
  int compared = 0, mismatched = 0, n_done = 0;
  bit auto_ack = 1'b0, ack_man = 1'b0, req_prev = 1'b0;
  int ack_lag = 0;
  typedef struct {logic rq; logic [DW-1:0] d; logic rd; logic dn; logic er;} exp_t;
  exp_t sb[$];
  logic [DW-1:0] tx_q[$];

  always #5 clk = ~clk;

  twophase_tx_fsm #(.DATA_WIDTH(DW), .SETUP_CYCLES(SU), .SYNC_STAGES(SS)
`ifdef TX_TIMEOUT_EN
    , .TIMEOUT_CYCLES(TO)
`endif
  ) dut (
    .clk(clk), .reset(reset), .v(v), .input_tx(input_tx), .ack(ack),
    .req(req), .output_tx(output_tx), .ready(ready), .done(done)
`ifdef TX_TIMEOUT_EN
    , .err(err)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: one transfer in flight; a setup countdown, then "up" (req expected) until the
  // delayed ack is seen, then "rel" until the delayed ack clears. ah is ack as the DUT sees it.
  bit busy, up, as, dn, er;
  int left, tcnt;
  logic [DW-1:0] word;
  bit [SS-1:0] ah;
  exp_t e;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy = 0; up = 0; left = 0; tcnt = 0; word = '0; ah = '0;
      sb.delete();
    end else begin
      as = ah[SS-1]; dn = 0; er = 0;
      if (!busy) begin
        if (v && !as) begin busy = 1; word = input_tx; left = SU; end
      end else if (left > 0) begin
        left--;
        if (left == 0) begin up = 1; tcnt = 0; end
      end else if (up) begin
        if (as) begin up = 0; tcnt = 0; end
        else if (TMO && tcnt == TO - 1) begin up = 0; busy = 0; er = 1; end
        else tcnt++;
      end else begin
        if (!as) begin busy = 0; dn = 1; end
        else if (TMO && tcnt == TO - 1) begin busy = 0; er = 1; end
        else tcnt++;
      end
      ah = {ah[SS-2:0], ack};
      e = '{up, word, !busy && !ah[SS-1], dn, er};
      sb.push_back(e);
    end
  end

  // Monitor: pops one expectation per cycle and compares every output.
  exp_t m;
  always @(negedge clk) if (reset && sb.size() > 0) begin
    m = sb.pop_front();
    chk("req", {31'd0, req}, {31'd0, m.rq});
    chk("output_tx", {24'd0, output_tx}, {24'd0, m.d});
    chk("ready", {31'd0, ready}, {31'd0, m.rd});
    chk("done", {31'd0, done}, {31'd0, m.dn});
`ifdef TX_TIMEOUT_EN
    chk("err", {31'd0, err}, {31'd0, m.er});
`endif
    if (done) n_done++;
  end

  // Remote receiver: checks delivered order at each req rise and mirrors req onto ack.
  always @(posedge clk) begin
    #1;
    if (req && !req_prev) begin
      if (tx_q.size() == 0) begin
        compared++; mismatched++;
        $display("FAIL word_order: got %0h expected no request", output_tx);
      end else chk("word_order", {24'd0, output_tx}, {24'd0, tx_q.pop_front()});
    end
    req_prev = req;
    if (!auto_ack) ack = ack_man;
    else if (ack !== req && $urandom_range(ack_lag, 0) == 0) ack = req;
  end

  task automatic send(input logic [DW-1:0] w);
    bit acc = 0;
    int k = 0;
    v = 1; input_tx = w;
    while (!acc && k < 200) begin
      @(negedge clk); acc = ready;
      @(posedge clk); #1; k++;
    end
    compared++;
    if (!acc) begin mismatched++; $display("FAIL accept: word %0h not taken within %0d cycles", w, k); end
    else tx_q.push_back(w);
    v = 0;
  endtask

  task automatic wait_done(input int lim);
    int k = 0;
    int d0 = n_done;
    while (n_done == d0 && k < lim) begin @(posedge clk); k++; end
    #1;
    compared++;
    if (n_done == d0) begin mismatched++; $display("FAIL done_pulse: got none expected one within %0d cycles", lim); end
  endtask

  initial begin
    int d0, k;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", {31'd0, req}, 0);
    chk("rst_output_tx", {24'd0, output_tx}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_ready", {31'd0, ready}, 1);
    reset = 1;
    auto_ack = 1; ack_lag = 0;
    send(8'hA5);
    wait_done(60);
    // back-to-back with v effectively held high between words
    d0 = n_done;
    send(8'h01); send(8'h02); send(8'h03);
    wait_done(60);
    chk("b2b_dones", n_done - d0, 3);
    // stale ack held through a reset release
    auto_ack = 0; ack_man = 1;
    @(posedge clk); #1;
    reset = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1;
    repeat (3) @(posedge clk);
    #1 v = 1; input_tx = 8'h3C;
    repeat (4) begin
      @(negedge clk);
      chk("stale_ready", {31'd0, ready}, 0);
      chk("stale_req", {31'd0, req}, 0);
      chk("stale_output_tx", {24'd0, output_tx}, 0);
    end
    ack_man = 0;
    @(posedge clk); #1;
    auto_ack = 1;
    send(8'h3C);
    wait_done(80);
    // reset while waiting for ack
    auto_ack = 0; ack_man = 0;
    send(8'h5A);
    k = 0;
    while (!req && k < 40) begin @(negedge clk); k++; end
    chk("mid_req_high", {31'd0, req}, 1);
    @(posedge clk); #2 reset = 0;
    #1;
    chk("async_req", {31'd0, req}, 0);
    chk("async_output_tx", {24'd0, output_tx}, 0);
    @(posedge clk); @(posedge clk); #2 reset = 1;
    d0 = n_done;
    repeat (20) @(posedge clk);
    #1;
    chk("no_done_after_reset", n_done - d0, 0);
    // randomized traffic with random receiver latency
    auto_ack = 1;
    repeat (40) begin
      ack_lag = $urandom_range(3, 0);
      send(DW'($urandom));
      repeat ($urandom_range(4, 0)) @(posedge clk);
      #1;
    end
    wait_done(100);
`ifdef TX_TIMEOUT_EN
    // receiver never answers: transfer must be abandoned after TO cycles of req
    repeat (4) @(posedge clk);
    #1 auto_ack = 0; ack_man = 0;
    send(8'h77);
    k = 0;
    while (!req && k < 50) begin @(negedge clk); k++; end
    k = 0;
    while (req && k < 40) begin @(negedge clk); k++; end
    chk("tmo_req_cycles", k, TO);
    repeat (4) @(posedge clk);
    #1;
`endif
    chk("tx_q_drained", tx_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/twophase_tx_fsm.md
Name: twophase_tx_fsm

Overview:
- Transmitter end of the four-phase req/ack data handshake between cores.
- Accepts a word from the local core, drives it onto the inter-core bus and raises req.
- Waits for the receiver's ack through a two-flop synchronizer, then completes the return-to-zero phase.
- Pairs with the receiving FSM on the far clock domain; req, ack and output_tx cross the domain boundary.

Parameters:
- DATA_WIDTH, 8, width of the data bus.
- SETUP_CYCLES, 1, cycles output_tx is held stable before req rises (1..15).
- SYNC_STAGES, 2, flip-flops in the ack synchronizer (minimum 2; raise for MTBF).

Ports:
- clk  input  1  single clock.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- v  input  1  local core has a word to send; sampled only when ready=1.
- input_tx  input  DATA_WIDTH  word from the local core.
- ack  input  1  acknowledge from the remote receiver; asynchronous to clk.
- req  output  1  request to the receiver; registered, glitch-free.
- output_tx  output  DATA_WIDTH  data bus to the receiver; registered.
- ready  output  1  block can accept a new word this cycle.
- done  output  1  one-cycle pulse when a transfer fully completes.

Behaviour:
- Reset (reset=0, asynchronous) sets:
  - state to IDLE, req=0, output_tx=0, done=0;
  - all synchronizer flops and the setup counter to 0.
- Ack synchronizer: SYNC_STAGES flops clocked by clk; ack_s is the last stage. Latency from ack to ack_s is SYNC_STAGES edges. Raw ack is never used in logic.
- ready is combinational: state==IDLE && ack_s==0.
- States, 2-bit encoding:
  - IDLE=00:
    - if v && ready, capture input_tx into output_tx, clear the setup counter and go to SETUP;
    - otherwise hold, with output_tx unchanged.
  - SETUP=01:
    - req stays 0 and the counter increments;
    - when counter==SETUP_CYCLES-1, set req=1 and go to WAIT_ACK.
  - WAIT_ACK=10:
    - req=1 and output_tx is frozen;
    - when ack_s==1, set req=0 and go to WAIT_REL.
  - WAIT_REL=11:
    - req=0 and output_tx is still frozen;
    - when ack_s==0, pulse done=1 for one cycle and go to IDLE.
- Accept latency: req rises SETUP_CYCLES edges after the edge that captured v.
- Back-to-back: a new v is accepted no earlier than the cycle after done, because ready rises with the IDLE return.
- Full round trip (SETUP_CYCLES=1, SYNC_STAGES=2, receiver acks immediately): at least 6 clk cycles.
- output_tx changes only on the IDLE capture edge. It never changes while req=1 or while ack_s=1.
- v in any state other than IDLE is ignored. It is not queued; the local core must hold v until it sees ready.
- ack_s=1 while in IDLE (stale ack left from a far-side reset) holds ready=0 until ack_s falls. No new req is issued.
- ack_s falling in WAIT_ACK before it has ever risen is a no-op; the FSM keeps waiting.
- Reset mid-transfer:
  - req and output_tx drop to 0 asynchronously;
  - after release, the FSM resumes from IDLE and obeys the stale-ack rule above.
- Unreachable encodings are not possible with 2 bits. The default branch forces IDLE with req=0.

Optional Feature:
- Macro: TX_TIMEOUT_EN.
- When defined:
  - adds parameter TIMEOUT_CYCLES (default 255) and output err (1 bit, reset 0);
  - a counter runs in WAIT_ACK and in WAIT_REL and is cleared on every state entry;
  - if it reaches TIMEOUT_CYCLES, set req=0, pulse err for one cycle, skip done, and go to IDLE;
  - the IDLE stale-ack rule still blocks ready until ack_s==0.
- When undefined: no counter and no err port; the FSM waits indefinitely.

Test Plan:
- Basic transfer: reset low for 3 cycles, then v=1 with input_tx=8'hA5. Expect ready=0 next cycle, output_tx=A5, req=1 after 1 cycle, and req not dropping before ack_s rises. Hold ack=1 until req=0, then drop ack. Expect one done pulse and ready=1.
- Back-to-back words 8'h01, 8'h02, 8'h03 with v held high and an auto-acking model. Expect three done pulses, output_tx stable whenever req=1, and words delivered in order.
- Stale ack: force ack=1 through reset release, then apply v=1 with 8'h3C. Expect ready=0, req=0 and output_tx=0 until 2 cycles after ack falls; then 3C is accepted.
- Reset mid-transfer: assert reset while in WAIT_ACK with req=1. Expect req=0 and output_tx=0 immediately, without waiting for clk. Expect no done pulse after release.
- Setup parameter: with SETUP_CYCLES=4 and v=1 on 8'hFF, expect req to rise exactly 4 edges after the capture edge.
- TX_TIMEOUT_EN with TIMEOUT_CYCLES=10 and ack held at 0: expect req=1 for 10 cycles, then req=0, one err pulse, no done, and ready=1 on the next cycle.
